oam_dma_arbiter: RTL

//  Shares the external CPU bus between the Cpu6502 core and the NES sprite (OAM) DMA engine.
//  A CPU write to the DMA register halts the core through o_cpu_rdy.
//  The block then copies TRANSFER_COUNT bytes from page {i_cpu_data,8'h00} to OAM_DATA_ADDR
//  as read/write pairs, and returns the bus to the CPU. It sits between Cpu6502 and the memory map.

---
 rtl/oam_dma_arbiter_if.sv | 37 +++
 rtl/oam_dma_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter_if.sv
// oam_dma_arbiter_if
//   CPU-side and memory-map-side bus signals of the OAM DMA arbiter.
//   slave  : the arbiter (takes CPU request + bus read data, drives bus + CPU ready)
//   master : the environment (CPU core + memory map, or a testbench)
//   Signals:
//     i_cpu_rw      CPU read/write, 1=read 0=write
//     i_cpu_address CPU address
//     i_cpu_data    CPU write data
//     o_cpu_data    read data returned to the CPU (mirrors i_data)
//     o_cpu_rdy     1 = CPU advances, 0 = CPU holds all state
//     o_rw          bus read/write to memory map
//     o_address     bus address
//     o_data        bus write data
//     i_data        bus read data, valid in the same cycle as o_address
//     o_dma_active  1 while a DMA is in progress
interface oam_dma_arbiter_if;
  logic        i_cpu_rw;
  logic [15:0] i_cpu_address;
  logic [7:0]  i_cpu_data;
  logic [7:0]  o_cpu_data;
  logic        o_cpu_rdy;
  logic        o_rw;
  logic [15:0] o_address;
  logic [7:0]  o_data;
  logic [7:0]  i_data;
  logic        o_dma_active;

  modport slave (
    input  i_cpu_rw, i_cpu_address, i_cpu_data, i_data,
    output o_cpu_data, o_cpu_rdy, o_rw, o_address, o_data, o_dma_active
  );

  modport master (
    output i_cpu_rw, i_cpu_address, i_cpu_data, i_data,
    input  o_cpu_data, o_cpu_rdy, o_rw, o_address, o_data, o_dma_active
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter
//   Shares the external bus between the 6502 core and the sprite (OAM) DMA
//   engine. A CPU write to DMA_REG_ADDR halts the core and copies
//   TRANSFER_COUNT bytes from page {data,8'h00} to OAM_DATA_ADDR as
//   read/write pairs, then hands the bus back.
//   Ports:
//     i_clk    clock
//     i_reset  synchronous active-high reset
//     bus      oam_dma_arbiter_if.slave (CPU request, memory bus, CPU ready)
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR   = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR  = 16'h2004,
  parameter int unsigned TRANSFER_COUNT = 256
) (
  input  logic              i_clk,
  input  logic              i_reset,
  oam_dma_arbiter_if.slave  bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HALT  = 3'd1;
  localparam logic [2:0] ST_ALIGN = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  localparam logic [8:0] LAST_INDEX = 9'(TRANSFER_COUNT - 1);

  logic [2:0] state_q, state_d;
  logic       parity_q;
  logic [8:0] index_q, index_d;
  logic [7:0] page_q, page_d;
  logic [7:0] latch_q, latch_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      parity_q <= 1'b0;
      index_q  <= '0;
      page_q   <= '0;
      latch_q  <= '0;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      index_q  <= index_d;
      page_q   <= page_d;
      latch_q  <= latch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    page_d  = page_q;
    latch_d = latch_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.i_cpu_rw && bus.i_cpu_address == DMA_REG_ADDR) begin
          page_d  = bus.i_cpu_data;
          index_d = '0;
          state_d = ST_HALT;
        end
      end
      // parity_q is the parity of the HALT cycle itself; if HALT is even the
      // following cycle is odd, so one ALIGN cycle pushes READ onto even.
      ST_HALT:  state_d = (parity_q == 1'b0) ? ST_ALIGN : ST_READ;
      ST_ALIGN: state_d = ST_READ;
      ST_READ: begin
        latch_d = bus.i_data;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (index_q == LAST_INDEX) begin
          state_d = ST_IDLE;
        end else begin
          index_d = index_q + 9'd1;
          state_d = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs depend only on registered state and the CPU request, never on
  // i_data (apart from the plain read-data return path).
  always_comb begin
    bus.o_cpu_rdy    = 1'b0;
    bus.o_dma_active = 1'b1;
    bus.o_rw         = 1'b1;
    bus.o_address    = bus.i_cpu_address;
    bus.o_data       = 8'h00;
    unique case (state_q)
      ST_IDLE: begin
        bus.o_cpu_rdy    = 1'b1;
        bus.o_dma_active = 1'b0;
        bus.o_rw         = bus.i_cpu_rw;
        bus.o_address    = bus.i_cpu_address;
        bus.o_data       = bus.i_cpu_data;
      end
      ST_HALT, ST_ALIGN: begin
        bus.o_address = bus.i_cpu_address;
      end
      // Only the low 8 index bits form the source offset: no carry into page.
      ST_READ: begin
        bus.o_address = {page_q, index_q[7:0]};
      end
      ST_WRITE: begin
        bus.o_rw      = 1'b0;
        bus.o_address = OAM_DATA_ADDR;
        bus.o_data    = latch_q;
      end
      default: begin
        bus.o_cpu_rdy    = 1'b1;
        bus.o_dma_active = 1'b0;
      end
    endcase
  end

  assign bus.o_cpu_data = bus.i_data;

endmodule
